if_stage: RTL

Instruction-fetch stage of the five-stage pipeline: owns the program counter and the IF/ID pipeline register. Drives the word address and chip-enable into the combinational instruction ROM and takes back the instruction in the same cycle. Registers the pc/instruction pair for the decode stage. Applies stall, branch redirect and exception flush with a fixed priority.

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_stage_if_id.sv | 51 +++++
 rtl/if_stage.sv | 73 +++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage widths, reset pc, stall bit indices and pc state type
package if_stage_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int STALL_W     = 6;

  localparam logic [INST_W-1:0]      ZERO_WORD = '0;
  localparam logic [INST_ADDR_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;

  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  typedef enum logic {
    PC_IDLE = 1'b0,
    PC_RUN  = 1'b1
  } pc_state_e;

  // Sequential successor; wraps silently at the top of the address space.
  function automatic logic [INST_ADDR_W-1:0] next_seq_pc(input logic [INST_ADDR_W-1:0] cur);
    return cur + PC_STEP;
  endfunction

endpackage

// File: rtl/if_stage_if_id.sv
// rtl/if_stage_if_id.sv - IF/ID pipeline register with flush, bubble and wrong-path squash
// Optional macro BRANCH_DELAY_SLOT_EN keeps the instruction fetched alongside a taken branch.
module if_stage_if_id
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic                   flush,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic [INST_W-1:0]      inst,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst
);

  logic squash;

`ifdef BRANCH_DELAY_SLOT_EN
  logic unused_branch_flag;
  assign unused_branch_flag = branch_flag;
  assign squash = 1'b0;
`else
  assign squash = branch_flag & ~stall_if;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc   <= ZERO_WORD;
      id_inst <= ZERO_WORD;
    end else if (flush) begin
      id_pc   <= ZERO_WORD;
      id_inst <= ZERO_WORD;
    end else if (stall_if && !stall_id) begin
      // IF stalled while ID moves on: hand ID a nop rather than a duplicate.
      id_pc   <= ZERO_WORD;
      id_inst <= ZERO_WORD;
    end else if (stall_if) begin
      id_pc   <= id_pc;
      id_inst <= id_inst;
    end else if (squash) begin
      id_pc   <= ZERO_WORD;
      id_inst <= ZERO_WORD;
    end else begin
      id_pc   <= pc;
      id_inst <= inst;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: program counter, ROM enable and IF/ID register
// Optional macro BRANCH_DELAY_SLOT_EN selects the architectural branch delay slot.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  input  logic [INST_W-1:0]      inst_i,
  output logic [INST_ADDR_W-1:0] pc,
  output logic                   ce,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst
);

  pc_state_e              state, state_next;
  logic [INST_ADDR_W-1:0] pc_next;

  logic unused_stall_hi;
  assign unused_stall_hi = ^stall[STALL_W-1:STALL_ID+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PC_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ce         = 1'b0;
    case (state)
      PC_IDLE: begin
        state_next = PC_RUN;
        pc_next    = RESET_PC;
      end
      PC_RUN: begin
        ce = 1'b1;
        // A branch seen under a pc stall is dropped; ID re-presents it later.
        if (flush)                pc_next = new_pc;
        else if (stall[STALL_PC]) pc_next = pc;
        else if (branch_flag_i)   pc_next = branch_target_address_i;
        else                      pc_next = next_seq_pc(pc);
      end
      default: begin
        state_next = PC_IDLE;
        pc_next    = RESET_PC;
      end
    endcase
  end

  if_stage_if_id u_if_id (
    .clk         (clk),
    .rst         (rst),
    .stall_if    (stall[STALL_IF]),
    .stall_id    (stall[STALL_ID]),
    .flush       (flush),
    .branch_flag (branch_flag_i),
    .pc          (pc),
    .inst        (inst_i),
    .id_pc       (id_pc),
    .id_inst     (id_inst)
  );

endmodule
